// File: rtl/sdram_device_model.sv
// Cycle-accurate SDRAM responder: decodes commands, tracks open rows per bank,
// stores write bursts and returns read bursts after the programmed CAS latency.
module sdram_device_model #(
  parameter int unsigned ROW_BITS   = 2,
  parameter int unsigned CL_DEFAULT = 3,
  parameter int unsigned TRCD       = 3,
  parameter int unsigned TRP        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_cle,
  input  logic        sdram_cs,
  input  logic        sdram_ras,
  input  logic        sdram_cas,
  input  logic        sdram_we,
  input  logic        sdram_dqm,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic [31:0] sdram_dqo,
  output logic [31:0] sdram_dqi,
  output logic        rd_valid,
  output logic [5:0]  err
);

  localparam int unsigned COL_BITS   = 8;
  localparam int unsigned IDX_BITS   = 2 + ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH      = 1 << IDX_BITS;
  localparam int unsigned PIPE_DEPTH = 7;
  localparam int unsigned TMAX       = (TRCD > TRP) ? TRCD : TRP;
  localparam int unsigned CW         = $clog2(TMAX + 2);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  localparam logic [2:0] OP_LMR = 3'b000;
  localparam logic [2:0] OP_REF = 3'b001;
  localparam logic [2:0] OP_PRE = 3'b010;
  localparam logic [2:0] OP_ACT = 3'b011;
  localparam logic [2:0] OP_WR  = 3'b100;
  localparam logic [2:0] OP_RD  = 3'b101;
  localparam logic [2:0] OP_BT  = 3'b110;

  logic [31:0]         mem [DEPTH];

  logic [3:0]          bank_open;
  logic [ROW_BITS-1:0] open_row  [4];
  logic [CW-1:0]       since_act [4];
  logic [CW-1:0]       since_pre [4];

  logic [2:0]          cl;
  logic [1:0]          bl_log;

  logic                burst_active;
  logic                burst_rd;
  logic                burst_zero;
  logic [1:0]          burst_bank;
  logic [ROW_BITS-1:0] burst_row;
  logic [7:0]          burst_col;
  logic [2:0]          burst_k;

  logic                pipe_v [PIPE_DEPTH];
  logic                pipe_z [PIPE_DEPTH];
  logic [IDX_BITS-1:0] pipe_a [PIPE_DEPTH];

  logic                sel;
  logic [2:0]          op;
  logic                is_act, is_rd, is_wr, is_bt, is_pre, is_ref, is_lmr;
  logic                tgt_open;
  logic [7:0]          col;
  logic [7:0]          bl_mask;
  logic [7:0]          burst_col_k;
  logic [IDX_BITS-1:0] cur_idx;
  logic                trunc;
  logic                cont;
  logic                issue_v;
  logic                issue_z;
  logic [IDX_BITS-1:0] issue_a;
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  logic [31:0]         wr_data;
  logic [3:0]          act_mask;
  logic [3:0]          pre_mask;
  logic [5:0]          err_set;
  logic                unused_a;

  assign unused_a = ^sdram_a[12:11];

  // Command decode, burst continuation and violation detection
  always_comb begin
    sel         = sdram_cle & ~sdram_cs;
    op          = {sdram_ras, sdram_cas, sdram_we};
    is_act      = sel && (op == OP_ACT);
    is_rd       = sel && (op == OP_RD);
    is_wr       = sel && (op == OP_WR);
    is_bt       = sel && (op == OP_BT);
    is_pre      = sel && (op == OP_PRE);
    is_ref      = sel && (op == OP_REF);
    is_lmr      = sel && (op == OP_LMR);
    tgt_open    = bank_open[sdram_ba];
    col         = sdram_a[9:2];
    cur_idx     = {sdram_ba, open_row[sdram_ba], col};

    bl_mask = 8'h00;
    case (bl_log)
      2'd1:    bl_mask = 8'h01;
      2'd2:    bl_mask = 8'h03;
      2'd3:    bl_mask = 8'h07;
      default: bl_mask = 8'h00;
    endcase
    burst_col_k = (burst_col & ~bl_mask) | ((burst_col + 8'(burst_k)) & bl_mask);

    trunc = burst_active && (is_rd || is_wr || is_bt ||
            (is_pre && (sdram_a[10] || (sdram_ba == burst_bank))));
    cont  = burst_active && sdram_cle && !trunc;

    issue_v = 1'b0;
    issue_z = 1'b0;
    issue_a = '0;
    if (is_rd) begin
      issue_v = 1'b1;
      issue_z = sdram_dqm | ~tgt_open;
      issue_a = cur_idx;
    end else if (cont && burst_rd) begin
      issue_v = 1'b1;
      issue_z = burst_zero;
      issue_a = {burst_bank, burst_row, burst_col_k};
    end

    // A new READ at the same edge as a write beat wins via trunc
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = sdram_dqo;
    if (is_wr && tgt_open && !sdram_dqm) begin
      wr_en  = 1'b1;
      wr_idx = cur_idx;
    end else if (cont && !burst_rd && !sdram_dqm) begin
      wr_en  = 1'b1;
      wr_idx = {burst_bank, burst_row, burst_col_k};
    end

    act_mask = is_act ? (4'b0001 << sdram_ba) : 4'b0000;
    pre_mask = 4'b0000;
    if (is_pre) pre_mask = sdram_a[10] ? 4'b1111 : (4'b0001 << sdram_ba);

    err_set    = 6'b000000;
    err_set[0] = is_act && tgt_open;
    err_set[1] = (is_rd || is_wr) && !tgt_open;
    err_set[2] = is_ref && (|bank_open);
    err_set[3] = (is_rd || is_wr) && tgt_open && (since_act[sdram_ba] < CW'(TRCD));
    err_set[4] = is_act && (since_pre[sdram_ba] < CW'(TRP));
    err_set[5] = is_lmr && (sdram_a[2] || (sdram_a[6:4] == 3'd0) ||
                 (|bank_open) || burst_active);
  end

  // Storage array is deliberately not reset
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sdram_dqi    <= 32'h0;
      rd_valid     <= 1'b0;
      err          <= 6'b000000;
      bank_open    <= 4'b0000;
      cl           <= 3'(CL_DEFAULT);
      bl_log       <= 2'd0;
      burst_active <= 1'b0;
      burst_rd     <= 1'b0;
      burst_zero   <= 1'b0;
      burst_bank   <= 2'd0;
      burst_row    <= '0;
      burst_col    <= 8'h00;
      burst_k      <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        open_row[i]  <= '0;
        since_act[i] <= CNT_SAT;
        since_pre[i] <= CNT_SAT;
      end
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_z[i] <= 1'b0;
        pipe_a[i] <= '0;
      end
    end else if (sdram_cle) begin
      err <= err | err_set;

      for (int i = 0; i < 4; i++) begin
        since_act[i] <= (since_act[i] == CNT_SAT) ? CNT_SAT : since_act[i] + CW'(1);
        since_pre[i] <= (since_pre[i] == CNT_SAT) ? CNT_SAT : since_pre[i] + CW'(1);
        if (act_mask[i]) begin
          bank_open[i] <= 1'b1;
          open_row[i]  <= sdram_a[ROW_BITS-1:0];
          since_act[i] <= CW'(1);
        end
        if (pre_mask[i]) begin
          bank_open[i] <= 1'b0;
          since_pre[i] <= CW'(1);
        end
      end

      // Beat issued at edge T lands in slot CL-1 and leaves the register at T+CL
      for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
        pipe_v[i] <= pipe_v[i+1];
        pipe_z[i] <= pipe_z[i+1];
        pipe_a[i] <= pipe_a[i+1];
      end
      pipe_v[PIPE_DEPTH-1] <= 1'b0;
      if (issue_v) begin
        pipe_v[cl - 3'd1] <= 1'b1;
        pipe_z[cl - 3'd1] <= issue_z;
        pipe_a[cl - 3'd1] <= issue_a;
      end

      if (pipe_v[0]) begin
        rd_valid  <= 1'b1;
        sdram_dqi <= pipe_z[0] ? 32'h0 : mem[pipe_a[0]];
      end else begin
        rd_valid  <= 1'b0;
      end

      if (is_lmr) begin
        bl_log <= sdram_a[2] ? 2'd0 : sdram_a[1:0];
        if (sdram_a[6:4] != 3'd0) cl <= sdram_a[6:4];
      end

      if (is_rd || is_wr) begin
        burst_active <= (bl_log != 2'd0) && (is_rd || tgt_open);
        burst_rd     <= is_rd;
        burst_zero   <= sdram_dqm | ~tgt_open;
        burst_bank   <= sdram_ba;
        burst_row    <= open_row[sdram_ba];
        burst_col    <= col;
        burst_k      <= 3'd1;
      end else if (trunc) begin
        burst_active <= 1'b0;
      end else if (cont) begin
        burst_k <= burst_k + 3'd1;
        if (burst_k >= bl_mask[2:0]) burst_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_device_model.sv
// Directed bench for sdram_device_model: decode, latency, burst wrap,
// interruption, masking, violation flags and reset cancellation.
module tb_sdram_device_model;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clk;
  logic        rst;
  logic        cle;
  logic        cs, ras, cas, we;
  logic        dqm;
  logic [1:0]  ba;
  logic [12:0] a;
  logic [31:0] dqo;
  logic [31:0] dqi;
  logic        rd_valid;
  logic [5:0]  err;

  int tests  = 0;
  int errors = 0;

  sdram_device_model #(
    .ROW_BITS(2), .CL_DEFAULT(3), .TRCD(3), .TRP(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sdram_cle (cle),
    .sdram_cs  (cs),
    .sdram_ras (ras),
    .sdram_cas (cas),
    .sdram_we  (we),
    .sdram_dqm (dqm),
    .sdram_ba  (ba),
    .sdram_a   (a),
    .sdram_dqo (dqo),
    .sdram_dqi (dqi),
    .rd_valid  (rd_valid),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drv(input logic [3:0] c, input logic [1:0] b, input logic [12:0] ad,
                     input logic m, input logic [31:0] d);
    @(negedge clk);
    {cs, ras, cas, we} = c;
    ba  = b;
    a   = ad;
    dqm = m;
    dqo = d;
  endtask

  task automatic nop();
    drv(C_NOP, 2'd0, 13'h0, 1'b0, 32'h0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) nop();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {cs, ras, cas, we} = C_NOP;
    dqm = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (dqi !== 32'h0) begin errors++; $display("FAIL reset_dqi got %h want %h", dqi, 32'h0); end
    tests++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    tests++;
    if (err !== 6'b0) begin errors++; $display("FAIL reset_err got %b want 000000", err); end
  endtask

  task automatic test_basic_rw();
    drv(C_ACT, 2'd1, 13'd5, 1'b0, 32'h0);
    nops(2);
    drv(C_WR, 2'd1, 13'h040, 1'b0, 32'hDEADBEEF);
    drv(C_RD, 2'd1, 13'h040, 1'b0, 32'h0);
    nops(3);
    tests++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", rd_valid); end
    nop();
    tests++;
    if (dqi !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data got %h want deadbeef", dqi); end
    tests++;
    if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", rd_valid); end
    nop();
    tests++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", rd_valid); end
    tests++;
    if (err !== 6'b0) begin errors++; $display("FAIL basic_err got %b want 000000", err); end
  endtask

  task automatic test_burst_wrap();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'd3; exp_w[1] = 32'd4; exp_w[2] = 32'd1; exp_w[3] = 32'd2;
    drv(C_PRE, 2'd0, 13'h400, 1'b0, 32'h0);
    drv(C_LMR, 2'd0, 13'h022, 1'b0, 32'h0);
    nop();
    drv(C_ACT, 2'd1, 13'd5, 1'b0, 32'h0);
    nops(2);
    drv(C_WR, 2'd1, 13'h010, 1'b0, 32'd1);
    drv(C_NOP, 2'd0, 13'h0, 1'b0, 32'd2);
    drv(C_NOP, 2'd0, 13'h0, 1'b0, 32'd3);
    drv(C_NOP, 2'd0, 13'h0, 1'b0, 32'd4);
    drv(C_RD, 2'd1, 13'h018, 1'b0, 32'h0);
    nops(2);
    for (int k = 0; k < 4; k++) begin
      nop();
      tests++;
      if (dqi !== exp_w[k] || rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_beat%0d got %h/%b want %h/1", k, dqi, rd_valid, exp_w[k]);
      end
    end
    nop();
    tests++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL wrap_end got %b want 0", rd_valid); end
    tests++;
    if (err !== 6'b0) begin errors++; $display("FAIL wrap_err got %b want 000000", err); end
  endtask

  task automatic test_closed_and_double_act();
    do_reset();
    drv(C_RD, 2'd0, 13'h000, 1'b0, 32'h0);
    nops(4);
    tests++;
    if (dqi !== 32'h0 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL closed_read got %h/%b want 0/1", dqi, rd_valid);
    end
    tests++;
    if (err !== 6'b000010) begin errors++; $display("FAIL closed_err got %b want 000010", err); end
    drv(C_ACT, 2'd0, 13'd1, 1'b0, 32'h0);
    drv(C_ACT, 2'd0, 13'd2, 1'b0, 32'h0);
    nop();
    tests++;
    if (err !== 6'b000011) begin errors++; $display("FAIL double_act got %b want 000011", err); end
  endtask

  task automatic test_timing();
    do_reset();
    drv(C_ACT, 2'd1, 13'd5, 1'b0, 32'h0);
    drv(C_RD, 2'd1, 13'h040, 1'b0, 32'h0);
    nops(4);
    tests++;
    if (err !== 6'b001000) begin errors++; $display("FAIL trcd_err got %b want 001000", err); end
    tests++;
    if (dqi !== 32'hDEADBEEF || rd_valid !== 1'b1) begin
      errors++; $display("FAIL trcd_data got %h/%b want deadbeef/1", dqi, rd_valid);
    end
    drv(C_PRE, 2'd1, 13'h000, 1'b0, 32'h0);
    drv(C_ACT, 2'd1, 13'd5, 1'b0, 32'h0);
    nop();
    tests++;
    if (err !== 6'b011000) begin errors++; $display("FAIL trp_err got %b want 011000", err); end
  endtask

  task automatic test_lmr_err();
    do_reset();
    drv(C_LMR, 2'd0, 13'h004, 1'b0, 32'h0);
    nop();
    tests++;
    if (err !== 6'b100000) begin errors++; $display("FAIL lmr_err got %b want 100000", err); end
    drv(C_ACT, 2'd1, 13'd5, 1'b0, 32'h0);
    nops(2);
    drv(C_RD, 2'd1, 13'h040, 1'b0, 32'h0);
    nops(3);
    tests++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL lmr_cl_early got %b want 0", rd_valid); end
    nop();
    tests++;
    if (dqi !== 32'hDEADBEEF || rd_valid !== 1'b1) begin
      errors++; $display("FAIL lmr_cl_kept got %h/%b want deadbeef/1", dqi, rd_valid);
    end
    nop();
    tests++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL lmr_bl1 got %b want 0", rd_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [10];
    exp_w[0] = 32'h100; exp_w[1] = 32'h101; exp_w[2] = 32'h104; exp_w[3] = 32'h105;
    exp_w[4] = 32'h106; exp_w[5] = 32'h107; exp_w[6] = 32'h100; exp_w[7] = 32'h101;
    exp_w[8] = 32'h102; exp_w[9] = 32'h103;
    do_reset();
    drv(C_LMR, 2'd0, 13'h033, 1'b0, 32'h0);
    drv(C_ACT, 2'd2, 13'd0, 1'b0, 32'h0);
    nops(2);
    drv(C_WR, 2'd2, 13'h000, 1'b0, 32'h100);
    for (int i = 1; i < 8; i++) drv(C_NOP, 2'd0, 13'h0, 1'b0, 32'h100 + 32'(i));
    drv(C_RD, 2'd2, 13'h000, 1'b0, 32'h0);
    nop();
    drv(C_RD, 2'd2, 13'h010, 1'b0, 32'h0);
    nop();
    for (int k = 0; k < 10; k++) begin
      nop();
      tests++;
      if (dqi !== exp_w[k] || rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_beat%0d got %h/%b want %h/1", k, dqi, rd_valid, exp_w[k]);
      end
    end
    nop();
    tests++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", rd_valid); end
    drv(C_WR, 2'd2, 13'h000, 1'b1, 32'h0BAD);
    for (int i = 1; i < 8; i++) drv(C_NOP, 2'd0, 13'h0, 1'b1, 32'h0BAD);
    drv(C_RD, 2'd2, 13'h000, 1'b0, 32'h0);
    nops(4);
    tests++;
    if (dqi !== 32'h100 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL dqm_write got %h/%b want 00000100/1", dqi, rd_valid);
    end
    nops(8);
    tests++;
    if (err !== 6'b0) begin errors++; $display("FAIL b2b_err got %b want 000000", err); end
  endtask

  task automatic test_refresh_and_reset();
    drv(C_REF, 2'd0, 13'h0, 1'b0, 32'h0);
    nop();
    tests++;
    if (err !== 6'b000100) begin errors++; $display("FAIL refresh_err got %b want 000100", err); end
    drv(C_RD, 2'd2, 13'h000, 1'b0, 32'h0);
    nops(4);
    tests++;
    if (rd_valid !== 1'b1) begin errors++; $display("FAIL midburst_valid got %b want 1", rd_valid); end
    @(negedge clk);
    rst = 1'b1;
    {cs, ras, cas, we} = C_NOP;
    @(negedge clk);
    tests++;
    if (rd_valid !== 1'b0 || err !== 6'b0 || dqi !== 32'h0) begin
      errors++; $display("FAIL rst_midburst got %b/%b/%h want 0/000000/0", rd_valid, err, dqi);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nop();
      tests++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_flush%0d got %b want 0", i, rd_valid); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cle = 1'b1;
    {cs, ras, cas, we} = C_NOP;
    dqm = 1'b0;
    ba  = 2'd0;
    a   = 13'h0;
    dqo = 32'h0;
    test_reset();
    test_basic_rw();
    test_burst_wrap();
    test_closed_and_double_act();
    test_timing();
    test_lmr_err();
    test_back_to_back();
    test_refresh_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
